csr_unit: RTL and testbench
===========================

Name: csr_unit

Overview:
Machine-mode CSR file and trap-state holder. It produces the E_csr read value that the EX-stage result mux forwards as the ALU-stage output for SYSTEM-opcode (7'b1110011) instructions. It commits Zicsr writes, runs the cycle and instret counters, and performs mepc/mcause/mstatus updates on trap entry and mret. It drives mtvec/mepc to the PC-select logic and an interrupt request to the pipeline controller.

Parameters:
MTVEC_RST, 32'h0000_0000, reset value of mtvec (bits 1:0 forced 0)
HART_ID, 32'd0, value returned by mhartid

Ports:
clk  in  1  core clock
rst_n  in  1  synchronous active-low reset
E_op  in  7  EX-stage opcode
E_funct3  in  3  EX-stage funct3
E_csr_addr  in  12  EX-stage imm[11:0] CSR address
E_rs1_data  in  32  forwarded rs1 value
E_zimm  in  5  rs1 field; zero-extended immediate / rs1-is-x0 test
E_valid  in  1  EX instruction is valid, not stalled, not flushed
W_retire  in  1  one instruction retired this cycle
trap_take  in  1  pipeline commits a trap this cycle
trap_epc  in  32  PC to save on trap
trap_cause  in  32  mcause value to save on trap
mret_take  in  1  pipeline commits mret this cycle
ext_irq  in  1  external interrupt level (MEIP)
tmr_irq  in  1  timer interrupt level (MTIP)
E_csr  out  32  current (pre-write) value of addressed CSR
irq_req  out  1  enabled interrupt pending and mstatus.MIE=1
mtvec_o  out  32  trap vector base
mepc_o  out  32  return address for mret

Behaviour:
- Decoded CSR instruction: E_op==7'b1110011 and E_funct3!=3'b000.
- E_csr is combinational: it always returns the current register value at E_csr_addr (pre-write value, as CSRR* requires). Unimplemented addresses read 32'h0.
- Implemented CSRs:
  - mstatus 0x300: MIE bit3, MPIE bit7, MPP[12:11] hardwired 2'b11, other bits 0.
  - mie 0x304: MTIE bit7, MEIE bit11 writable.
  - mip 0x344: read-only; MTIP=tmr_irq, MEIP=ext_irq.
  - mtvec 0x305; mepc 0x341 (bits 1:0 forced 0); mcause 0x342.
  - mcycle/mcycleh 0xB00/0xB80; minstret/minstreth 0xB02/0xB82.
  - Read-only aliases: cycle/cycleh 0xC00/0xC80; instret/instreth 0xC02/0xC82; mhartid 0xF14.
- Source operand: E_rs1_data for funct3 001/010/011; {27'b0,E_zimm} for 101/110/111.
- New value:
  - RW: src.
  - RS: old|src.
  - RC: old&~src.
- Write enable: E_valid && decoded && writable address && !(RS/RC form && E_zimm==0). The write commits on the next rising edge, so the updated value is visible the following cycle. Writes to read-only or unimplemented addresses are silently ignored.
- Counters: mcycle increments every cycle, 64-bit, wraps to 0. minstret increments when W_retire=1. A CSR write to either half in the same cycle wins over the increment for the whole 64-bit counter that cycle; the other half holds.
- Trap entry (trap_take=1):
  - mepc<=trap_epc&~3, mcause<=trap_cause.
  - MPIE<=MIE, MIE<=0.
- mret (mret_take=1): MIE<=MPIE, MPIE<=1.
- Priority within one cycle: trap_take > mret_take > CSR write. The lower-priority update to mstatus/mepc/mcause is dropped. Counters are unaffected by this priority.
- irq_req = mstatus.MIE & ((MEIE&ext_irq)|(MTIE&tmr_irq)), combinational.
- Reset (rst_n=0 at clk edge):
  - mstatus MIE=0, MPIE=0.
  - mie=0, mepc=0, mcause=0, mtvec=MTVEC_RST&~3.
  - Counters=0.
- Outputs after reset: irq_req=0, mtvec_o=MTVEC_RST&~3, mepc_o=0. Reset mid-operation overrides all pending writes, traps and increments.

Decomposition:
- csr_pkg holds:
  - CSR address localparams.
  - funct3 codes (CSRRW..CSRRCI).
  - mstatus/mie/mip bit-index constants.
  - SYSTEM opcode constant.
- Sub-module csr_counter64: 64-bit counter with inc input, lo/hi write enables and write data, and 64-bit value output. It is instantiated twice, once for mcycle and once for minstret.

Test Plan:
- Reset, then CSRRW 0x305 with rs1=32'h0000_1003 -> that cycle E_csr=0; next cycle mtvec_o=32'h0000_1000.
- CSRRS 0x300 with zimm=5'd8 -> MIE=1. Then CSRRC 0x300 with zimm=0 -> no write, E_csr=32'h0000_1808.
- mie=32'h800, ext_irq=1, MIE=1 -> irq_req=1. Then trap_take with epc=32'h0000_0206, cause=32'h8000_000B -> mepc_o=32'h204, MIE=0, MPIE=1, irq_req=0.
- mret_take following the trap -> MIE=1, MPIE=1. Same-cycle trap_take+mret_take -> trap result only.
- Preload mcycle lo=32'hFFFF_FFFF, hi=0 -> next cycle mcycle=64'h1_0000_0000. Write to 0xC00 -> ignored.
- W_retire high for 3 cycles, with a CSRRW 0xB02=5 in the 2nd cycle -> minstret=6 after the 3rd cycle. rst_n low mid-sequence -> all counters 0.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR file: opcode, funct3 encodings,
// CSR addresses and register bit positions.
package csr_pkg;

  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_INSTRET   = 12'hC02;
  localparam logic [11:0] A_CYCLEH    = 12'hC80;
  localparam logic [11:0] A_INSTRETH  = 12'hC82;
  localparam logic [11:0] A_MHARTID   = 12'hF14;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIE_MTIE     = 7;
  localparam int MIE_MEIE     = 11;
  localparam int MIP_MTIP     = 7;
  localparam int MIP_MEIP     = 11;

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with per-half load; a load of either half
// suppresses the increment for the whole counter that cycle. 1-cycle update, no backpressure.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] value
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value <= '0;
    end else if (wr_lo || wr_hi) begin
      if (wr_lo) value[31:0]  <= wdata;
      if (wr_hi) value[63:32] <= wdata;
    end else if (inc) begin
      value <= value + 64'd1;
    end
  end

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file with trap/mret state; combinational pre-write read,
// writes commit on the next edge. No backpressure: every accepted op completes in one cycle.
module csr_unit
  import csr_pkg::*;
#(
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
  parameter logic [31:0] HART_ID   = 32'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  E_op,
  input  logic [2:0]  E_funct3,
  input  logic [11:0] E_csr_addr,
  input  logic [31:0] E_rs1_data,
  input  logic [4:0]  E_zimm,
  input  logic        E_valid,
  input  logic        W_retire,
  input  logic        trap_take,
  input  logic [31:0] trap_epc,
  input  logic [31:0] trap_cause,
  input  logic        mret_take,
  input  logic        ext_irq,
  input  logic        tmr_irq,
  output logic [31:0] E_csr,
  output logic        irq_req,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o
);

  logic        st_mie, st_mpie, ie_mtie, ie_meie;
  logic [31:0] mtvec, mepc, mcause;
  logic [63:0] mcycle, minstret;
  logic [31:0] mstatus_val, mie_val, mip_val;
  logic [31:0] src, wdata;
  logic        decoded, writable, we;

  always_comb begin
    mstatus_val = '0;
    mstatus_val[MSTATUS_MIE]  = st_mie;
    mstatus_val[MSTATUS_MPIE] = st_mpie;
    mstatus_val[12:11]        = 2'b11;
    mie_val = '0;
    mie_val[MIE_MTIE] = ie_mtie;
    mie_val[MIE_MEIE] = ie_meie;
    mip_val = '0;
    mip_val[MIP_MTIP] = tmr_irq;
    mip_val[MIP_MEIP] = ext_irq;
  end

  always_comb begin
    E_csr = '0;
    case (E_csr_addr)
      A_MSTATUS:              E_csr = mstatus_val;
      A_MIE:                  E_csr = mie_val;
      A_MIP:                  E_csr = mip_val;
      A_MTVEC:                E_csr = mtvec;
      A_MEPC:                 E_csr = mepc;
      A_MCAUSE:               E_csr = mcause;
      A_MCYCLE,   A_CYCLE:    E_csr = mcycle[31:0];
      A_MCYCLEH,  A_CYCLEH:   E_csr = mcycle[63:32];
      A_MINSTRET, A_INSTRET:  E_csr = minstret[31:0];
      A_MINSTRETH, A_INSTRETH: E_csr = minstret[63:32];
      A_MHARTID:              E_csr = HART_ID;
      default:                E_csr = '0;
    endcase
  end

  always_comb begin
    writable = 1'b0;
    case (E_csr_addr)
      A_MSTATUS, A_MIE, A_MTVEC, A_MEPC, A_MCAUSE,
      A_MCYCLE, A_MCYCLEH, A_MINSTRET, A_MINSTRETH: writable = 1'b1;
      default: writable = 1'b0;
    endcase
  end

  assign decoded = (E_op == OP_SYSTEM) && (E_funct3 != 3'b000);
  assign src     = E_funct3[2] ? {27'b0, E_zimm} : E_rs1_data;

  always_comb begin
    wdata = src;
    case (E_funct3[1:0])
      2'b10:   wdata = E_csr | src;
      2'b11:   wdata = E_csr & ~src;
      default: wdata = src;
    endcase
  end

  // Set/clear forms with a zero rs1 field are pure reads and must not write.
  assign we = E_valid && decoded && (E_funct3[1:0] != 2'b00) && writable &&
              !(E_funct3[1] && (E_zimm == 5'd0));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mtvec   <= MTVEC_RST & ~32'd3;
      ie_mtie <= 1'b0;
      ie_meie <= 1'b0;
    end else if (we) begin
      if (E_csr_addr == A_MTVEC) mtvec <= wdata & ~32'd3;
      if (E_csr_addr == A_MIE) begin
        ie_mtie <= wdata[MIE_MTIE];
        ie_meie <= wdata[MIE_MEIE];
      end
    end
  end

  // Trap beats mret beats software write for the trap-state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_mie  <= 1'b0;
      st_mpie <= 1'b0;
      mepc    <= '0;
      mcause  <= '0;
    end else if (trap_take) begin
      mepc    <= trap_epc & ~32'd3;
      mcause  <= trap_cause;
      st_mpie <= st_mie;
      st_mie  <= 1'b0;
    end else if (mret_take) begin
      st_mie  <= st_mpie;
      st_mpie <= 1'b1;
    end else if (we) begin
      case (E_csr_addr)
        A_MSTATUS: begin
          st_mie  <= wdata[MSTATUS_MIE];
          st_mpie <= wdata[MSTATUS_MPIE];
        end
        A_MEPC:   mepc   <= wdata & ~32'd3;
        A_MCAUSE: mcause <= wdata;
        default: ;
      endcase
    end
  end

  csr_counter64 u_mcycle (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (1'b1),
    .wr_lo (we && (E_csr_addr == A_MCYCLE)),
    .wr_hi (we && (E_csr_addr == A_MCYCLEH)),
    .wdata (wdata),
    .value (mcycle)
  );

  csr_counter64 u_minstret (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (W_retire),
    .wr_lo (we && (E_csr_addr == A_MINSTRET)),
    .wr_hi (we && (E_csr_addr == A_MINSTRETH)),
    .wdata (wdata),
    .value (minstret)
  );

  assign irq_req = st_mie & ((ie_meie & ext_irq) | (ie_mtie & tmr_irq));
  assign mtvec_o = mtvec;
  assign mepc_o  = mepc;

endmodule

// File: tb/tb_csr_unit.sv
// Directed bench for csr_unit: expectations are queued as each step is driven
// and compared against the DUT on the following falling edge.
module tb_csr_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  E_op;
  logic [2:0]  E_funct3;
  logic [11:0] E_csr_addr;
  logic [31:0] E_rs1_data;
  logic [4:0]  E_zimm;
  logic        E_valid, W_retire, trap_take, mret_take, ext_irq, tmr_irq;
  logic [31:0] trap_epc, trap_cause;
  logic [31:0] E_csr, mtvec_o, mepc_o;
  logic        irq_req;

  int checks = 0;
  int failures = 0;

  int          sel_q[$];
  logic [31:0] exp_q[$];
  string       tag_q[$];

  localparam int S_CSR = 0, S_IRQ = 1, S_TVEC = 2, S_EPC = 3;

  csr_unit #(.MTVEC_RST(32'h0000_0103), .HART_ID(32'd5)) dut (
    .clk(clk), .rst_n(rst_n), .E_op(E_op), .E_funct3(E_funct3),
    .E_csr_addr(E_csr_addr), .E_rs1_data(E_rs1_data), .E_zimm(E_zimm),
    .E_valid(E_valid), .W_retire(W_retire), .trap_take(trap_take),
    .trap_epc(trap_epc), .trap_cause(trap_cause), .mret_take(mret_take),
    .ext_irq(ext_irq), .tmr_irq(tmr_irq), .E_csr(E_csr), .irq_req(irq_req),
    .mtvec_o(mtvec_o), .mepc_o(mepc_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic exp_push(input int sel, input logic [31:0] val, input string tag);
    sel_q.push_back(sel);
    exp_q.push_back(val);
    tag_q.push_back(tag);
  endtask

  task automatic csr_op(input logic [2:0] f3, input logic [11:0] addr,
                        input logic [31:0] rs1, input logic [4:0] zimm);
    E_op = 7'b1110011;
    E_funct3 = f3;
    E_csr_addr = addr;
    E_rs1_data = rs1;
    E_zimm = zimm;
    E_valid = 1'b1;
  endtask

  // CSRRS with rs1=x0 reads without writing.
  task automatic rd(input logic [11:0] addr);
    csr_op(3'b010, addr, 32'hFFFF_FFFF, 5'd0);
  endtask

  task automatic step();
    int sel;
    logic [31:0] ev, obs;
    string tg;
    @(negedge clk);
    while (sel_q.size() > 0) begin
      sel = sel_q.pop_front();
      ev  = exp_q.pop_front();
      tg  = tag_q.pop_front();
      case (sel)
        S_CSR:   obs = E_csr;
        S_IRQ:   obs = {31'b0, irq_req};
        S_TVEC:  obs = mtvec_o;
        default: obs = mepc_o;
      endcase
      checks++;
      assert (obs === ev) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tg, obs, ev);
      end
    end
    @(posedge clk);
    #1;
    E_valid = 1'b0;
    E_op = 7'd0;
    E_funct3 = 3'd0;
    trap_take = 1'b0;
    mret_take = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    E_op = '0; E_funct3 = '0; E_csr_addr = '0; E_rs1_data = '0; E_zimm = '0;
    E_valid = 0; W_retire = 0; trap_take = 0; mret_take = 0;
    ext_irq = 0; tmr_irq = 0; trap_epc = '0; trap_cause = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    rd(12'h300);
    exp_push(S_CSR, 32'h0000_1800, "rst_mstatus");
    exp_push(S_IRQ, 32'd0, "rst_irq");
    exp_push(S_TVEC, 32'h0000_0100, "rst_mtvec");
    exp_push(S_EPC, 32'd0, "rst_mepc");
    step();
    rd(12'hF14);   exp_push(S_CSR, 32'd5, "mhartid"); step();
    rd(12'h123);   exp_push(S_CSR, 32'd0, "unimpl_read"); step();

    csr_op(3'b001, 12'h305, 32'h0000_1003, 5'd1);
    exp_push(S_CSR, 32'h0000_0100, "mtvec_prewrite");
    step();
    rd(12'h305);
    exp_push(S_TVEC, 32'h0000_1000, "mtvec_o_written");
    exp_push(S_CSR, 32'h0000_1000, "mtvec_read");
    step();

    csr_op(3'b110, 12'h300, 32'd0, 5'd8);
    exp_push(S_CSR, 32'h0000_1800, "csrrsi_pre");
    step();
    csr_op(3'b111, 12'h300, 32'd0, 5'd0);
    exp_push(S_CSR, 32'h0000_1808, "csrrci_zero_pre");
    step();
    rd(12'h300);   exp_push(S_CSR, 32'h0000_1808, "csrrci_zero_nowrite"); step();

    ext_irq = 1'b1;
    csr_op(3'b001, 12'h304, 32'h0000_0800, 5'd2);
    exp_push(S_IRQ, 32'd0, "irq_before_mie");
    step();
    tmr_irq = 1'b1;
    rd(12'h344);
    exp_push(S_CSR, 32'h0000_0880, "mip");
    exp_push(S_IRQ, 32'd1, "irq_enabled");
    step();
    rd(12'h304);   exp_push(S_CSR, 32'h0000_0800, "mie_read"); step();

    tmr_irq = 1'b0;
    trap_take = 1'b1; trap_epc = 32'h0000_0206; trap_cause = 32'h8000_000B;
    csr_op(3'b001, 12'h341, 32'h0000_DEAD, 5'd3);
    step();
    rd(12'h300);
    exp_push(S_EPC, 32'h0000_0204, "trap_mepc");
    exp_push(S_IRQ, 32'd0, "trap_irq_off");
    exp_push(S_CSR, 32'h0000_1880, "trap_mstatus");
    step();
    rd(12'h342);   exp_push(S_CSR, 32'h8000_000B, "trap_mcause"); step();

    mret_take = 1'b1;
    csr_op(3'b001, 12'h300, 32'd0, 5'd4);
    step();
    rd(12'h300);
    exp_push(S_CSR, 32'h0000_1888, "mret_mstatus");
    exp_push(S_IRQ, 32'd1, "mret_irq_on");
    step();

    trap_take = 1'b1; mret_take = 1'b1;
    trap_epc = 32'h0000_0300; trap_cause = 32'd7;
    step();
    rd(12'h300);
    exp_push(S_CSR, 32'h0000_1880, "trap_over_mret");
    exp_push(S_EPC, 32'h0000_0300, "trap_over_mret_epc");
    exp_push(S_IRQ, 32'd0, "trap_over_mret_irq");
    step();
    rd(12'h342);   exp_push(S_CSR, 32'd7, "trap_over_mret_cause"); step();

    csr_op(3'b001, 12'hB80, 32'd0, 5'd1); step();
    csr_op(3'b001, 12'hB00, 32'hFFFF_FFFF, 5'd1); step();
    rd(12'hB00);   exp_push(S_CSR, 32'hFFFF_FFFF, "mcycle_preload"); step();
    rd(12'hC80);   exp_push(S_CSR, 32'd1, "mcycle_carry_hi"); step();
    rd(12'hB00);   exp_push(S_CSR, 32'd1, "mcycle_wrap_lo"); step();
    csr_op(3'b001, 12'hC00, 32'h0000_1234, 5'd1);
    exp_push(S_CSR, 32'd2, "cycle_alias_read");
    step();
    rd(12'hB00);   exp_push(S_CSR, 32'd3, "cycle_write_ignored"); step();

    rd(12'hB02);   exp_push(S_CSR, 32'd0, "minstret_idle"); step();
    W_retire = 1'b1;
    step();
    csr_op(3'b001, 12'hB02, 32'd5, 5'd1);
    step();
    step();
    W_retire = 1'b0;
    rd(12'hB02);   exp_push(S_CSR, 32'd6, "minstret_write_wins"); step();
    rd(12'hC02);   exp_push(S_CSR, 32'd6, "instret_alias"); step();
    rd(12'hB82);   exp_push(S_CSR, 32'd0, "minstreth"); step();

    W_retire = 1'b1;
    rst_n = 1'b0;
    csr_op(3'b001, 12'h305, 32'h0000_4000, 5'd1);
    step();
    rst_n = 1'b1;
    W_retire = 1'b0;
    rd(12'hB02);
    exp_push(S_CSR, 32'd0, "midrst_minstret");
    exp_push(S_TVEC, 32'h0000_0100, "midrst_mtvec");
    exp_push(S_EPC, 32'd0, "midrst_mepc");
    exp_push(S_IRQ, 32'd0, "midrst_irq");
    step();
    rd(12'hB80);   exp_push(S_CSR, 32'd0, "midrst_mcycleh"); step();
    rd(12'h300);   exp_push(S_CSR, 32'h0000_1800, "midrst_mstatus"); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
